// File: rtl/img_pix_stream_reader.sv
// Pixel stream reader: requests pixels one at a time from an upstream source, buffers them in a FIFO
// and exposes data/status/control over an Avalon-MM slave. Optional PIXCOUNT via IMG_READER_PIXCOUNT_EN.
module img_pix_stream_reader #(
    parameter int PIX_W = 24,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             get_next_pix,
    input  logic             pix_rdy,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             img_done,
    output logic             cpu_rdy,
    output logic [3:0]       out_state
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_WAIT  = 4'd2,
        ST_DONE  = 4'd3,
        ST_DRAIN = 4'd4
    } state_t;

    state_t            state_q, state_d, fsm_next_s;
    logic [PIX_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] count_q, count_d;
    logic              run_q, run_d, underflow_q, underflow_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              get_next_pix_q, cpu_rdy_q;
    logic              ctrl_wr_s, clear_s, data_rd_s, push_s, pop_s, empty_s, full_s;
    logic [31:0]       status_s, pixcnt_rd_s;
    logic              unused_s;

    assign ctrl_wr_s = avs_write && (avs_address == 2'd2);
    assign clear_s   = ctrl_wr_s && avs_writedata[1];
    assign data_rd_s = avs_read && (avs_address == 2'd0);
    assign empty_s   = (count_q == '0);
    assign full_s    = (count_q == FILL_W'(DEPTH));
    // A clear in the same cycle as pix_rdy drops that pixel
    assign push_s    = (state_q == ST_WAIT) && pix_rdy && !clear_s;
    assign pop_s     = data_rd_s && !empty_s && !clear_s;
    assign unused_s  = ^avs_writedata[31:2];

    assign status_s = {4'd0, state_q, 3'd0, run_q, underflow_q, img_done, full_s, empty_s, 16'(count_q)};

`ifdef IMG_READER_PIXCOUNT_EN
    logic [CNT_W-1:0] pixcnt_q, pixcnt_d;

    // Pushed-pixel counter, wraps naturally
    always_comb begin
        pixcnt_d = pixcnt_q;
        if (clear_s) begin
            pixcnt_d = '0;
        end else if (push_s) begin
            pixcnt_d = pixcnt_q + CNT_W'(1);
        end else begin
            pixcnt_d = pixcnt_q;
        end
    end

    // Pixel counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixcnt_q <= '0;
        end else begin
            pixcnt_q <= pixcnt_d;
        end
    end

    assign pixcnt_rd_s = 32'(pixcnt_q);
`else
    assign pixcnt_rd_s = 32'd0;
`endif

    // Request FSM next state; a clear overrides normal sequencing
    always_comb begin
        fsm_next_s = state_q;
        case (state_q)
            ST_IDLE: begin
                if (img_done) begin
                    fsm_next_s = ST_DONE;
                end else if (run_q && !full_s) begin
                    fsm_next_s = ST_REQ;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_REQ:   fsm_next_s = ST_WAIT;
            ST_WAIT: begin
                if (pix_rdy) begin
                    fsm_next_s = img_done ? ST_DONE : ST_IDLE;
                end else begin
                    fsm_next_s = ST_WAIT;
                end
            end
            ST_DONE:  fsm_next_s = ST_DONE;
            ST_DRAIN: begin
                if (pix_rdy) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_DRAIN;
                end
            end
            default:  fsm_next_s = ST_IDLE;
        endcase
        // A request already on the wire (REQ or WAIT) must have its reply swallowed
        if (clear_s) begin
            if ((state_q == ST_REQ) || (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !pix_rdy)) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = fsm_next_s;
        end
    end

    // FIFO pointers, fill count, run and sticky underflow
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        run_d       = ctrl_wr_s ? avs_writedata[0] : run_q;
        if (clear_s) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end else begin
            wr_ptr_d    = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            underflow_d = underflow_q | (data_rd_s && empty_s);
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + FILL_W'(1);
                2'b01:   count_d = count_q - FILL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Read data mux, captured one cycle after the strobe
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = empty_s ? 32'd0 : 32'(mem_q[rd_ptr_q]);
                2'd1:    rdata_d = status_s;
                2'd2:    rdata_d = {31'd0, run_q};
                2'd3:    rdata_d = pixcnt_rd_s;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FIFO storage; no reset needed as occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= pixel_data;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            run_q          <= 1'b0;
            underflow_q    <= 1'b0;
            rdata_q        <= 32'd0;
            get_next_pix_q <= 1'b0;
            cpu_rdy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            run_q          <= run_d;
            underflow_q    <= underflow_d;
            rdata_q        <= rdata_d;
            get_next_pix_q <= (state_d == ST_REQ);
            cpu_rdy_q      <= (count_d != '0);
        end
    end

    assign avs_readdata = rdata_q;
    assign get_next_pix = get_next_pix_q;
    assign cpu_rdy      = cpu_rdy_q;
    assign out_state    = state_q;

endmodule
